wdt_top: RTL and testbench

APB watchdog timer for the system control unit. It supplies the `rst_wdt_n` input of the reset generator. Software programs a timeout and must feed the dog with a magic value. A first expiry raises an interrupt. A second expiry without a feed drives a registered, fixed-width active-low reset pulse. It runs on the APB clock alongside the reset generator's register bank.

---
 rtl/wdt_top.sv | 234 +++++++++++++++++++++++
 tb/tb_wdt_top.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wdt_top.sv
// APB watchdog timer.
// First expiry raises a level interrupt (STAT.TIMEOUT). A second expiry
// without a feed, with RST_EN set, drives a fixed-width active-low reset
// request to the reset generator. Single clock domain (pclk).
module wdt_top #(
  parameter int unsigned  RST_PULSE_W = 16,
  parameter logic [31:0]  FEED_VAL    = 32'h5A5A_A5A5
) (
  input  logic        pclk,
  input  logic        prst_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [7:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        wdt_irq,
  output logic        rst_wdt_n
);

  localparam logic [7:0] ADDR_CTRL = 8'h00;
  localparam logic [7:0] ADDR_LOAD = 8'h04;
  localparam logic [7:0] ADDR_FEED = 8'h08;
  localparam logic [7:0] ADDR_CNT  = 8'h0C;
  localparam logic [7:0] ADDR_STAT = 8'h10;

  // Last value of the pulse counter before the reset request is released.
  localparam logic [7:0] PULSE_LAST = 8'(RST_PULSE_W - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_WARN  = 2'd2,
    ST_RESET = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] cnt_r;
  logic [31:0] cnt_nxt_s;
  logic [31:0] load_r;
  logic        en_r;
  logic        rst_en_r;
  logic        timeout_r;
  logic [7:0]  pulse_cnt_r;
  logic        rst_wdt_n_r;
  logic [31:0] prdata_s;

  logic        wr_s;
  logic        rd_s;
  logic        wr_ctrl_s;
  logic        wr_load_s;
  logic        wr_stat_s;
  logic        feed_s;
  logic        en_set_s;
  logic        en_clr_s;
  logic        cnt_zero_s;
  logic        set_timeout_s;
  logic        pulse_done_s;

  // APB access decode; everything is qualified by the access phase.
  assign wr_s       = psel & pwrite & penable;
  assign rd_s       = psel & ~pwrite & penable;
  assign wr_ctrl_s  = wr_s & (paddr == ADDR_CTRL);
  assign wr_load_s  = wr_s & (paddr == ADDR_LOAD);
  assign wr_stat_s  = wr_s & (paddr == ADDR_STAT);
  assign feed_s     = wr_s & (paddr == ADDR_FEED) & (pwdata == FEED_VAL);
  assign en_set_s   = wr_ctrl_s & pwdata[0];
  assign en_clr_s   = wr_ctrl_s & ~pwdata[0];
  assign cnt_zero_s = (cnt_r == 32'd0);

  // Next-state and counter update; priority: pulse, EN clear, feed, expiry.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    set_timeout_s = 1'b0;
    pulse_done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = load_r;
        if (en_set_s) begin
          state_nxt_s = ST_COUNT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (en_clr_s) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = load_r;
        end else if (feed_s) begin
          state_nxt_s = ST_COUNT;
          cnt_nxt_s   = load_r;
        end else if (cnt_zero_s) begin
          set_timeout_s = 1'b1;
          state_nxt_s   = ST_WARN;
          cnt_nxt_s     = load_r;
        end else begin
          state_nxt_s = ST_COUNT;
          cnt_nxt_s   = cnt_r - 32'd1;
        end
      end
      ST_WARN: begin
        if (en_clr_s) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = load_r;
        end else if (feed_s) begin
          state_nxt_s = ST_COUNT;
          cnt_nxt_s   = load_r;
        end else if (cnt_zero_s) begin
          if (rst_en_r) begin
            state_nxt_s = ST_RESET;
            cnt_nxt_s   = cnt_r;
          end else begin
            state_nxt_s = ST_WARN;
            cnt_nxt_s   = load_r;
          end
        end else begin
          state_nxt_s = ST_WARN;
          cnt_nxt_s   = cnt_r - 32'd1;
        end
      end
      ST_RESET: begin
        if (pulse_cnt_r == PULSE_LAST) begin
          pulse_done_s = 1'b1;
          state_nxt_s  = ST_IDLE;
          cnt_nxt_s    = load_r;
        end else begin
          state_nxt_s = ST_RESET;
          cnt_nxt_s   = cnt_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = load_r;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge pclk) begin
    if (!prst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 32'hFFFF_FFFF;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Reset pulse width counter; restarts from zero on every RESET entry.
  always_ff @(posedge pclk) begin
    if (!prst_n) begin
      pulse_cnt_r <= 8'd0;
    end else if (state_r == ST_RESET) begin
      pulse_cnt_r <= pulse_cnt_r + 8'd1;
    end else begin
      pulse_cnt_r <= 8'd0;
    end
  end

  // CTRL register; frozen during the reset pulse, cleared when it ends.
  always_ff @(posedge pclk) begin
    if (!prst_n) begin
      en_r     <= 1'b0;
      rst_en_r <= 1'b0;
    end else if (pulse_done_s) begin
      en_r     <= 1'b0;
      rst_en_r <= 1'b0;
    end else if (wr_ctrl_s && (state_r != ST_RESET)) begin
      en_r     <= pwdata[0];
      rst_en_r <= pwdata[1];
    end else begin
      en_r     <= en_r;
      rst_en_r <= rst_en_r;
    end
  end

  // LOAD register; zero would never expire sensibly, so it is stored as 1.
  always_ff @(posedge pclk) begin
    if (!prst_n) begin
      load_r <= 32'hFFFF_FFFF;
    end else if (wr_load_s) begin
      load_r <= (pwdata == 32'd0) ? 32'd1 : pwdata;
    end else begin
      load_r <= load_r;
    end
  end

  // STAT.TIMEOUT, write-1-to-clear; a simultaneous set takes precedence.
  always_ff @(posedge pclk) begin
    if (!prst_n) begin
      timeout_r <= 1'b0;
    end else if (set_timeout_s) begin
      timeout_r <= 1'b1;
    end else if (wr_stat_s && pwdata[0]) begin
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= timeout_r;
    end
  end

  // Registered reset request, low for exactly the cycles spent in RESET.
  always_ff @(posedge pclk) begin
    if (!prst_n) begin
      rst_wdt_n_r <= 1'b1;
    end else begin
      rst_wdt_n_r <= (state_nxt_s != ST_RESET);
    end
  end

  // Combinational read mux; zero outside a read access.
  always_comb begin
    prdata_s = 32'd0;
    if (rd_s) begin
      case (paddr)
        ADDR_CTRL: prdata_s = {30'd0, rst_en_r, en_r};
        ADDR_LOAD: prdata_s = load_r;
        ADDR_CNT:  prdata_s = cnt_r;
        ADDR_STAT: prdata_s = {31'd0, timeout_r};
        default:   prdata_s = 32'd0;
      endcase
    end else begin
      prdata_s = 32'd0;
    end
  end

  assign prdata    = prdata_s;
  assign pready    = 1'b1;
  assign wdt_irq   = timeout_r;
  assign rst_wdt_n = rst_wdt_n_r;

endmodule

// File: tb/tb_wdt_top.sv
// Self-checking bench for wdt_top: directed timing scenarios plus random APB
// traffic, all checked against a cycle-level behavioural model.
module tb_wdt_top;

  localparam int          PW   = 16;
  localparam logic [31:0] FVAL = 32'h5A5A_A5A5;

  logic        pclk = 1'b0;
  logic        prst_n = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [7:0]  paddr = 8'd0;
  logic [31:0] pwdata = 32'd0;
  logic [31:0] prdata;
  logic        pready;
  logic        wdt_irq;
  logic        rst_wdt_n;

  int n_checks = 0;
  int n_fail   = 0;
  bit irq_seen = 1'b0;
  bit rst_low_seen = 1'b0;

  // Behavioural model: watchdog described as running / warned / pulse-left.
  bit          m_en = 1'b0;
  bit          m_rst_en = 1'b0;
  bit          m_running = 1'b0;
  bit          m_warned = 1'b0;
  bit          m_timeout = 1'b0;
  int          m_pulse_left = 0;
  logic [31:0] m_load = 32'hFFFF_FFFF;
  logic [31:0] m_cnt = 32'hFFFF_FFFF;

  wdt_top #(.RST_PULSE_W(PW), .FEED_VAL(FVAL)) dut (
    .pclk(pclk), .prst_n(prst_n), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .wdt_irq(wdt_irq), .rst_wdt_n(rst_wdt_n)
  );

  // 100 MHz clock
  always #5 pclk = ~pclk;

  // Overall time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL time_limit: simulation did not complete (checks=%0d)", n_checks);
    $fatal(1, "time limit");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] a);
    case (a)
      8'h00:   return {30'd0, m_rst_en, m_en};
      8'h04:   return m_load;
      8'h0C:   return m_cnt;
      8'h10:   return {31'd0, m_timeout};
      default: return 32'd0;
    endcase
  endfunction

  // One rising edge of the model given the bus state sampled at that edge.
  task automatic model_step(input logic rst_ok, input logic wr, input logic [7:0] a, input logic [31:0] d);
    bit          wr_ctrl;
    bit          feed;
    bit          in_pulse;
    bit          set_to;
    logic [31:0] ld;
    wr_ctrl = wr && (a == 8'h00);
    feed    = wr && (a == 8'h08) && (d == FVAL);
    if (!rst_ok) begin
      m_en = 1'b0; m_rst_en = 1'b0; m_running = 1'b0; m_warned = 1'b0;
      m_timeout = 1'b0; m_pulse_left = 0;
      m_load = 32'hFFFF_FFFF; m_cnt = 32'hFFFF_FFFF;
      return;
    end
    in_pulse = (m_pulse_left > 0);
    set_to   = 1'b0;
    ld       = m_load;
    if (in_pulse) begin
      m_pulse_left--;
      if (m_pulse_left == 0) begin
        m_en = 1'b0; m_rst_en = 1'b0; m_cnt = ld;
      end
    end else if (!m_running) begin
      m_cnt = ld;
      if (wr_ctrl && d[0]) begin
        m_running = 1'b1; m_warned = 1'b0;
      end
    end else if (wr_ctrl && !d[0]) begin
      m_running = 1'b0; m_warned = 1'b0; m_cnt = ld;
    end else if (feed) begin
      m_cnt = ld; m_warned = 1'b0;
    end else if (m_cnt == 32'd0) begin
      if (!m_warned) begin
        set_to = 1'b1; m_warned = 1'b1; m_cnt = ld;
      end else if (m_rst_en) begin
        m_running = 1'b0; m_warned = 1'b0; m_pulse_left = PW;
      end else begin
        m_cnt = ld;
      end
    end else begin
      m_cnt = m_cnt - 32'd1;
    end
    if (wr_ctrl && !in_pulse) begin
      m_en = d[0]; m_rst_en = d[1];
    end
    if (wr && (a == 8'h04)) m_load = (d == 32'd0) ? 32'd1 : d;
    if (set_to) m_timeout = 1'b1;
    else if (wr && (a == 8'h10) && d[0]) m_timeout = 1'b0;
  endtask

  // Advance one clock, step the model, then compare the output pins.
  task automatic cyc();
    logic        r_ok;
    logic        w;
    logic [7:0]  a;
    logic [31:0] d;
    r_ok = prst_n; w = psel & pwrite & penable; a = paddr; d = pwdata;
    @(posedge pclk);
    model_step(r_ok, w, a, d);
    #1;
    check_eq("irq", {31'd0, wdt_irq}, {31'd0, m_timeout});
    check_eq("rst_wdt_n", {31'd0, rst_wdt_n}, {31'd0, (m_pulse_left == 0)});
    if (wdt_irq) irq_seen = 1'b1;
    if (!rst_wdt_n) rst_low_seen = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    cyc();
    penable = 1'b1;
    cyc();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
    cyc();
    penable = 1'b1;
    #1;
    d = prdata;
    if (!((a == 8'h0C) && (m_pulse_left > 0))) check_eq("read_model", d, model_read(a));
    cyc();
    psel = 1'b0; penable = 1'b0;
  endtask

  // Cycles until wdt_irq is seen high; bound+1 if it never rises.
  task automatic wait_irq(input int bound, output int n);
    n = 0;
    while (!wdt_irq && n <= bound) begin
      cyc();
      n++;
    end
  endtask

  task automatic wait_rst_low(input int bound, output int n);
    n = 0;
    while (rst_wdt_n && n <= bound) begin
      cyc();
      n++;
    end
  endtask

  logic [31:0] rd;
  int          n;
  logic [7:0]  addrs [6] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14};

  initial begin
    // Reset values
    prst_n = 1'b0;
    idle(2);
    prst_n = 1'b1;
    check_eq("rst_pin", {31'd0, rst_wdt_n}, 32'd1);
    check_eq("pready", {31'd0, pready}, 32'd1);
    apb_read(8'h00, rd); check_eq("rst_ctrl", rd, 32'd0);
    apb_read(8'h04, rd); check_eq("rst_load", rd, 32'hFFFF_FFFF);
    apb_read(8'h0C, rd); check_eq("rst_cnt", rd, 32'hFFFF_FFFF);
    apb_read(8'h10, rd); check_eq("rst_stat", rd, 32'd0);

    // First-stage expiry, LOAD=10: irq at E0+11 with CNT reloaded to 10
    apb_write(8'h04, 32'd10);
    apb_write(8'h00, 32'd1);
    idle(10);
    check_eq("irq_early", {31'd0, wdt_irq}, 32'd0);
    apb_read(8'h0C, rd);
    check_eq("cnt_at_expiry", rd, 32'd10);
    check_eq("irq_rise", {31'd0, wdt_irq}, 32'd1);
    apb_read(8'h10, rd); check_eq("stat_set", rd, 32'd1);
    apb_write(8'h10, 32'd1);
    check_eq("irq_w1c", {31'd0, wdt_irq}, 32'd0);
    apb_write(8'h00, 32'd0);

    // Full expiry to reset, LOAD=5
    apb_write(8'h04, 32'd5);
    apb_write(8'h00, 32'd3);
    wait_rst_low(100, n);
    check_eq("rst_assert_delay", n, 32'd12);
    n = 0;
    while (!rst_wdt_n && n < 100) begin
      cyc();
      n++;
    end
    check_eq("rst_pulse_width", n, PW);
    apb_read(8'h00, rd); check_eq("ctrl_after_rst", rd, 32'd0);
    apb_read(8'h10, rd); check_eq("stat_after_rst", rd, 32'd1);
    rst_low_seen = 1'b0;
    idle(20);
    apb_read(8'h0C, rd); check_eq("idle_after_rst", rd, 32'd5);
    check_eq("no_second_rst", {31'd0, rst_low_seen}, 32'd0);
    apb_write(8'h10, 32'd1);

    // Regular feeding keeps the dog quiet
    apb_write(8'h04, 32'd8);
    apb_write(8'h00, 32'd3);
    irq_seen = 1'b0; rst_low_seen = 1'b0;
    for (int i = 0; i < 17; i++) begin
      idle(4);
      apb_write(8'h08, FVAL);
    end
    check_eq("feed_no_irq", {31'd0, irq_seen}, 32'd0);
    check_eq("feed_no_rst", {31'd0, rst_low_seen}, 32'd0);
    // Wrong feed value is ignored: expiry 9 cycles after the last real feed
    apb_write(8'h08, 32'h0000_1234);
    wait_irq(50, n);
    check_eq("bad_feed_expiry", n + 2, 32'd9);

    // Feed in the same cycle as cnt==0 suppresses TIMEOUT
    apb_write(8'h00, 32'd0);
    apb_write(8'h10, 32'd1);
    apb_write(8'h00, 32'd3);
    idle(7);
    apb_write(8'h08, FVAL);
    check_eq("feed_at_zero_irq", {31'd0, wdt_irq}, 32'd0);
    idle(5);
    apb_read(8'h10, rd); check_eq("feed_at_zero_stat", rd, 32'd0);
    wait_irq(50, n);
    check_eq("feed_next_expiry", n, 32'd2);
    apb_write(8'h00, 32'd0);
    apb_write(8'h10, 32'd1);

    // LOAD of 0 is stored as 1
    apb_write(8'h04, 32'd0);
    apb_read(8'h04, rd); check_eq("load_zero", rd, 32'd1);

    // Clearing EN in WARN returns to IDLE without a reset
    apb_write(8'h04, 32'd5);
    apb_write(8'h00, 32'd3);
    wait_irq(50, n);
    check_eq("warn_entry", n, 32'd6);
    apb_write(8'h00, 32'd0);
    rst_low_seen = 1'b0;
    idle(30);
    check_eq("warn_clear_no_rst", {31'd0, rst_low_seen}, 32'd0);
    apb_read(8'h0C, rd); check_eq("warn_clear_idle", rd, 32'd5);
    apb_write(8'h10, 32'd1);

    // prst_n during the reset pulse aborts it at that edge
    apb_write(8'h04, 32'd3);
    apb_write(8'h00, 32'd3);
    wait_rst_low(100, n);
    check_eq("pulse_start", n, 32'd8);
    idle(2);
    prst_n = 1'b0;
    cyc();
    check_eq("abort_rst_pin", {31'd0, rst_wdt_n}, 32'd1);
    check_eq("abort_irq", {31'd0, wdt_irq}, 32'd0);
    prst_n = 1'b1;
    apb_read(8'h04, rd); check_eq("abort_load", rd, 32'hFFFF_FFFF);

    // Write-only and unmapped reads
    apb_write(8'h14, 32'hFFFF_FFFF);
    apb_read(8'h08, rd); check_eq("read_feed", rd, 32'd0);
    apb_read(8'h14, rd); check_eq("read_unmapped", rd, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 35) begin
        idle($urandom_range(1, 4));
      end else if (r < 50) begin
        apb_write(8'h08, FVAL);
      end else if (r < 54) begin
        apb_write(8'h08, $urandom);
      end else if (r < 64) begin
        apb_write(8'h00, {$urandom_range(0, 255), 24'd0} | 32'($urandom_range(0, 3)));
      end else if (r < 70) begin
        apb_write(8'h04, 32'($urandom_range(0, 20)));
      end else if (r < 76) begin
        apb_write(8'h10, $urandom);
      end else if (r < 94) begin
        apb_read(addrs[$urandom_range(0, 5)], rd);
      end else if (r < 98) begin
        apb_write(8'h0C, $urandom);
      end else begin
        prst_n = 1'b0;
        cyc();
        prst_n = 1'b1;
      end
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
